// File: rtl/qdpong_pkg.sv
// Shared definitions for the quadrature paddle path: Gray-code states, direction
// encodings, default position geometry and the transition classifier.
package qdpong_pkg;

  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q01 = 2'b01;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q10 = 2'b10;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int DEF_POS_WIDTH = 6;
  localparam int DEF_POS_RESET = 32;

  typedef enum logic [1:0] {
    QD_NONE,
    QD_FWD,
    QD_REV,
    QD_ERR
  } qd_event_e;

  // Forward order is 00->01->11->10->00; any two-bit jump is illegal.
  function automatic qd_event_e qd_decode(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] fwd;
    logic [1:0] rev;
    qd_event_e  ev;
    unique case (prev)
      Q00:     begin fwd = Q01; rev = Q10; end
      Q01:     begin fwd = Q11; rev = Q00; end
      Q11:     begin fwd = Q10; rev = Q01; end
      default: begin fwd = Q00; rev = Q11; end
    endcase
    if (cur == prev)     ev = QD_NONE;
    else if (cur == fwd) ev = QD_FWD;
    else if (cur == rev) ev = QD_REV;
    else                 ev = QD_ERR;
    return ev;
  endfunction

endpackage

// File: rtl/paddle_quad_decoder_if.sv
// Encoder-side inputs and position/event outputs of the paddle decoder.
interface paddle_quad_decoder_if
  import qdpong_pkg::*;
#(
  parameter int POS_WIDTH = DEF_POS_WIDTH
);
  logic                 sample_en;
  logic                 enc_a;
  logic                 enc_b;
  logic [POS_WIDTH-1:0] position;
  logic                 step_valid;
  logic                 dir;
  logic                 error;

  modport master (
    output sample_en, enc_a, enc_b,
    input  position, step_valid, dir, error
  );

  modport slave (
    input  sample_en, enc_a, enc_b,
    output position, step_valid, dir, error
  );
endinterface

// File: rtl/enc_debounce.sv
// Two-flop synchroniser plus strobe-driven debounce for one encoder channel.
module enc_debounce #(
  parameter int DEBOUNCE_LEN = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sample_en,
  input  logic pin,
  output logic stable
);
  localparam int CNT_W = $clog2(DEBOUNCE_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LEN - 1);

  logic [1:0]       sync_q, sync_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d   = {sync_q[0], pin};
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sample_en) begin
      if (sync_q[1] == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        // The sample that would bring the run to DEBOUNCE_LEN is the accepting one.
        stable_d = sync_q[1];
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/paddle_quad_decoder.sv
// Debounced quadrature decoder producing a saturating paddle position with
// registered step/error pulses.
module paddle_quad_decoder
  import qdpong_pkg::*;
#(
  parameter int POS_WIDTH       = DEF_POS_WIDTH,
  parameter int POS_RESET       = DEF_POS_RESET,
  parameter int POS_MAX         = 63,
  parameter int DEBOUNCE_LEN    = 4,
  parameter int COUNTS_PER_STEP = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  paddle_quad_decoder_if.slave bus
);
  localparam int SC_W = $clog2(COUNTS_PER_STEP) + 1;
  localparam logic signed [SC_W-1:0] SC_HI  = SC_W'(COUNTS_PER_STEP - 1);
  localparam logic signed [SC_W-1:0] SC_LO  = -SC_HI;
  localparam logic signed [SC_W-1:0] SC_ONE = SC_W'(1);
  localparam logic [POS_WIDTH-1:0] POS_TOP  = POS_WIDTH'(POS_MAX);
  localparam logic [POS_WIDTH-1:0] POS_INIT = POS_WIDTH'(POS_RESET);

  logic                   stable_a, stable_b;
  logic [1:0]             qstate;
  logic [1:0]             prev_q, prev_d;
  logic signed [SC_W-1:0] sub_q, sub_d;
  logic [POS_WIDTH-1:0]   position_q, position_d;
  logic                   step_valid_q, step_valid_d;
  logic                   dir_q, dir_d;
  logic                   error_q, error_d;
  qd_event_e              ev;
  logic                   take_step;
  logic                   step_dir;

  enc_debounce #(.DEBOUNCE_LEN(DEBOUNCE_LEN)) u_deb_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .sample_en (bus.sample_en),
    .pin       (bus.enc_a),
    .stable    (stable_a)
  );

  enc_debounce #(.DEBOUNCE_LEN(DEBOUNCE_LEN)) u_deb_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .sample_en (bus.sample_en),
    .pin       (bus.enc_b),
    .stable    (stable_b)
  );

  assign qstate = {stable_a, stable_b};

  // Clamp to [0, POS_MAX]; callers detect a blocked step by an unchanged result.
  function automatic logic [POS_WIDTH-1:0] sat_step(input logic [POS_WIDTH-1:0] pos,
                                                     input logic               up);
    if (up) return (pos < POS_TOP) ? pos + 1'b1 : pos;
    return (pos != '0) ? pos - 1'b1 : pos;
  endfunction

  always_comb begin
    ev           = qd_decode(prev_q, qstate);
    prev_d       = qstate;
    sub_d        = sub_q;
    position_d   = position_q;
    dir_d        = dir_q;
    step_valid_d = 1'b0;
    error_d      = 1'b0;
    take_step    = 1'b0;
    step_dir     = DIR_UP;
    unique case (ev)
      QD_FWD: begin
        if (sub_q == SC_HI) begin
          sub_d     = '0;
          take_step = 1'b1;
          step_dir  = DIR_UP;
        end else begin
          sub_d = sub_q + SC_ONE;
        end
      end
      QD_REV: begin
        if (sub_q == SC_LO) begin
          sub_d     = '0;
          take_step = 1'b1;
          step_dir  = DIR_DOWN;
        end else begin
          sub_d = sub_q - SC_ONE;
        end
      end
      QD_ERR: begin
        sub_d   = '0;
        error_d = 1'b1;
      end
      default: ;
    endcase
    if (take_step) begin
      position_d = sat_step(position_q, step_dir);
      // At a limit the detent is swallowed: no pulse and dir keeps its last value.
      if (position_d != position_q) begin
        step_valid_d = 1'b1;
        dir_d        = step_dir;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q       <= Q00;
      sub_q        <= '0;
      position_q   <= POS_INIT;
      step_valid_q <= 1'b0;
      dir_q        <= DIR_DOWN;
      error_q      <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      sub_q        <= sub_d;
      position_q   <= position_d;
      step_valid_q <= step_valid_d;
      dir_q        <= dir_d;
      error_q      <= error_d;
    end
  end

  assign bus.position   = position_q;
  assign bus.step_valid = step_valid_q;
  assign bus.dir        = dir_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_paddle_quad_decoder.sv
// Directed bench for paddle_quad_decoder: a behavioural encoder model queues the
// expected pulses, a negedge monitor pops and compares them.
module tb_paddle_quad_decoder;

  typedef struct packed {
    logic       err;
    logic [5:0] pos;
    logic       dir;
  } sb_item_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  paddle_quad_decoder_if #(.POS_WIDTH(6)) bus ();

  paddle_quad_decoder #(
    .POS_WIDTH       (6),
    .POS_RESET       (32),
    .POS_MAX         (63),
    .DEBOUNCE_LEN    (4),
    .COUNTS_PER_STEP (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int step_cnt = 0;
  int err_cnt = 0;
  sb_item_t exp_q[$];

  logic [1:0] m_state = 2'b00;
  int         m_sub = 0;
  int         m_pos = 32;
  logic       m_dir = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int gidx(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gval(input int i);
    case (i)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Pulses come out in stimulus order, at most one per move.
  always @(negedge clk) begin
    if (reset_n && (bus.step_valid || bus.error)) begin
      sb_item_t it;
      if (bus.step_valid) step_cnt++;
      if (bus.error) err_cnt++;
      chk("pulse_excl", {31'd0, bus.step_valid & bus.error}, 0);
      chk("pulse_expected", {31'd0, exp_q.size() > 0}, 1);
      if (exp_q.size() > 0) begin
        it = exp_q.pop_front();
        chk("pulse_is_err", {31'd0, bus.error}, {31'd0, it.err});
        chk("pulse_pos", {26'd0, bus.position}, {26'd0, it.pos});
        chk("pulse_dir", {31'd0, bus.dir}, {31'd0, it.dir});
      end
    end
  end

  task automatic strobe(input int n);
    repeat (n) begin
      @(negedge clk) bus.sample_en = 1'b1;
      @(negedge clk) bus.sample_en = 1'b0;
    end
  endtask

  task automatic set_pins(input logic [1:0] ab);
    bus.enc_a = ab[1];
    bus.enc_b = ab[0];
    repeat (3) @(negedge clk);
  endtask

  task automatic step_model(input logic up);
    if (up && m_pos < 63) begin
      m_pos++; m_dir = 1'b1;
      exp_q.push_back('{err: 1'b0, pos: 6'(m_pos), dir: 1'b1});
    end else if (!up && m_pos > 0) begin
      m_pos--; m_dir = 1'b0;
      exp_q.push_back('{err: 1'b0, pos: 6'(m_pos), dir: 1'b0});
    end
  endtask

  // Hold a new encoder level long enough to be accepted and check the outcome.
  task automatic move(input logic [1:0] nxt);
    int d;
    d = (gidx(nxt) - gidx(m_state) + 4) % 4;
    if (d == 1) begin
      if (m_sub == 3) begin m_sub = 0; step_model(1'b1); end
      else m_sub++;
    end else if (d == 3) begin
      if (m_sub == -3) begin m_sub = 0; step_model(1'b0); end
      else m_sub--;
    end else if (d == 2) begin
      m_sub = 0;
      exp_q.push_back('{err: 1'b1, pos: 6'(m_pos), dir: m_dir});
    end
    m_state = nxt;
    set_pins(nxt);
    strobe(6);
    chk("sb_drained", exp_q.size(), 0);
    chk("position", {26'd0, bus.position}, m_pos);
    chk("dir", {31'd0, bus.dir}, {31'd0, m_dir});
  endtask

  task automatic detent(input logic up);
    for (int i = 0; i < 4; i++)
      move(gval((gidx(m_state) + (up ? 1 : 3)) % 4));
  endtask

  initial begin
    int s0;
    bus.sample_en = 1'b0;
    bus.enc_a = 1'b0;
    bus.enc_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_position", {26'd0, bus.position}, 32);
    reset_n = 1'b1;

    // Idle after reset
    chk("idle_position", {26'd0, bus.position}, 32);
    chk("idle_step", {31'd0, bus.step_valid}, 0);
    chk("idle_error", {31'd0, bus.error}, 0);
    chk("idle_dir", {31'd0, bus.dir}, 0);
    strobe(20);
    chk("idle2_position", {26'd0, bus.position}, 32);
    chk("idle2_steps", step_cnt, 0);

    // One detent forward, one back
    detent(1'b1);
    chk("fwd_position", {26'd0, bus.position}, 33);
    chk("fwd_dir", {31'd0, bus.dir}, 1);
    detent(1'b0);
    chk("rev_position", {26'd0, bus.position}, 32);
    chk("rev_dir", {31'd0, bus.dir}, 0);
    chk("fwd_rev_steps", step_cnt, 2);

    // Three-strobe glitch on A must be rejected
    s0 = step_cnt;
    set_pins(2'b10);
    strobe(3);
    set_pins(2'b00);
    strobe(6);
    chk("glitch_position", {26'd0, bus.position}, 32);
    chk("glitch_steps", step_cnt - s0, 0);
    chk("glitch_errors", err_cnt, 0);

    // Saturation at both ends
    s0 = step_cnt;
    for (int i = 0; i < 40; i++) detent(1'b1);
    chk("sat_hi_position", {26'd0, bus.position}, 63);
    chk("sat_hi_pulses", step_cnt - s0, 31);
    s0 = step_cnt;
    for (int i = 0; i < 70; i++) detent(1'b0);
    chk("sat_lo_position", {26'd0, bus.position}, 0);
    chk("sat_lo_pulses", step_cnt - s0, 63);

    // Illegal double-bit jumps clear the sub-count
    move(2'b11);
    move(2'b10);
    move(2'b01);
    chk("err_position", {26'd0, bus.position}, 0);
    chk("err_pulses", err_cnt, 2);
    detent(1'b1);
    chk("after_err_position", {26'd0, bus.position}, 1);

    // Unwind mid-detent, then asynchronous reset mid-detent
    s0 = step_cnt;
    move(2'b11);
    move(2'b10);
    move(2'b11);
    move(2'b01);
    chk("unwind_steps", step_cnt - s0, 0);
    move(2'b11);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_position", {26'd0, bus.position}, 32);
    chk("arst_step", {31'd0, bus.step_valid}, 0);
    chk("arst_error", {31'd0, bus.error}, 0);
    chk("arst_dir", {31'd0, bus.dir}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_state = 2'b00; m_sub = 0; m_pos = 32; m_dir = 1'b0;
    move(2'b11);
    s0 = step_cnt;
    move(2'b10);
    move(2'b00);
    move(2'b01);
    chk("post_rst_no_early_step", step_cnt - s0, 0);
    move(2'b11);
    chk("post_rst_position", {26'd0, bus.position}, 33);
    chk("total_errors", err_cnt, 3);
    chk("sb_final", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/paddle_quad_decoder.md
# paddle_quad_decoder

Debounced quadrature decoder turning the front-panel rotary encoder (enc_a/enc_b) into the 6-bit paddle position consumed by the pong top level. It sits directly upstream of the display/game logic. It replaces the separate slow sampling clock with a sample-enable strobe on the single system clock. Outputs are a saturating position counter plus step and error pulses for game logic and debug.

## Interface
- POS_WIDTH, 6, width of position output
- POS_RESET, 32, position after reset (paddle centred)
- POS_MAX, 63, upper saturation limit; lower limit fixed at 0
- DEBOUNCE_LEN, 4, consecutive differing samples required to accept a channel change (≥2)
- COUNTS_PER_STEP, 4, valid quadrature transitions per position step (≥1)

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset; one clock, no other clock domains
- sample_en  in  1  single-cycle strobe at debounce sampling rate (~16 kHz)
- enc_a  in  1  encoder channel A, asynchronous pin
- enc_b  in  1  encoder channel B, asynchronous pin
- position  out  POS_WIDTH  current paddle position, 0..POS_MAX
- step_valid  out  1  one-cycle pulse when position changes
- dir  out  1  direction of last position change: 1 = increment, 0 = decrement
- error  out  1  one-cycle pulse on illegal quadrature transition

## Operation
- Synchroniser: enc_a, enc_b each pass through 2 flops every clk; reset value 0.
- Debounce (per channel): stable bit (reset 0) and counter (reset 0). On sample_en: synced == stable → counter cleared; else counter increments, and when it reaches DEBOUNCE_LEN, stable takes the synced value and counter clears. No action without sample_en.
- Quadrature state = {stable_a, stable_b}; prev register (reset 00) updated every clk.
- Forward (+1): 00→01→11→10→00. Reverse (−1): the opposite order. No change: nothing.
- Both bits changed in one update (00↔11, 01↔10): error pulses, sub-count clears, no step; prev adopts the new state.
- Sub-count: signed, range ±(COUNTS_PER_STEP−1), reset 0. +1 at COUNTS_PER_STEP−1 → clears, step up; −1 at −(COUNTS_PER_STEP−1) → clears, step down; else add ±1. Reversal mid-detent unwinds without stepping.
- Position step up: position < POS_MAX → +1, step_valid=1, dir=1; at POS_MAX → unchanged, no step_valid, dir unchanged. Step down symmetric with floor 0 and dir=0. No wrap-around in either direction.
- Reset values: position=POS_RESET, step_valid=0, dir=0, error=0, sub-count=0.
- Reset mid-operation: all state returns to reset values immediately; the first decode afterwards compares against prev=00.

## Timing
- Pin-to-stable: 2 clk synchroniser, then DEBOUNCE_LEN consecutive sample_en strobes; stable updates on the edge of the final qualifying strobe.
- Stable-to-output: position, step_valid, dir and error register on the next clk edge (1-cycle latency).
- step_valid and error are registered, exactly 1 clk wide, and mutually exclusive.
- At most one stable change per channel per strobe, so at most one decode event per strobe.
- A simultaneous A and B change within one strobe is treated as illegal (error).

## Structure
- Shared package qdpong_pkg holds:
  - quadrature state constants (Q00, Q01, Q11, Q10)
  - DIR_UP/DIR_DOWN encodings
  - default POS_WIDTH and POS_RESET, for reuse by the display logic
- Sub-module enc_debounce (synchroniser + debounce for one channel, parameter DEBOUNCE_LEN), instantiated twice. Decode, sub-count and position stay in the top module.

## Test plan
- Reset, no activity → position=32, step_valid/error/dir=0 indefinitely.
- One full forward cycle 00→01→11→10→00, each level held 6 strobes → single step_valid, position=33, dir=1; opposite order → position=32, dir=0.
- 3-strobe glitch on enc_a (DEBOUNCE_LEN=4) → no stable change, no pulses, position unchanged.
- 40 forward detents from reset → position saturates at 63; exactly 31 step_valid pulses. Then 70 reverse detents → floor at 0; 63 pulses.
- enc_a and enc_b toggled together 00→11 → one error pulse, position unchanged, sub-count cleared; the next valid forward cycle steps normally.
- Two forward transitions then two reverse → no step_valid; assert reset_n low mid-detent → position=32, sub-count=0 asynchronously.
